// File: rtl/fft_pkg.sv
// Shared types for the FFT post-processing blocks: input FSM states, the tag that
// travels with each bin through the magnitude pipeline, and the bin-to-Hz product width.
package fft_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Tag index field is sized for the largest supported transform; narrower
  // instances zero-extend their bin index into it.
  localparam int MAX_IDX_W = 24;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] idx;
    logic                 first;
    logic                 last;
    logic                 drop;
  } pipe_tag_t;

  localparam int TAG_W = $bits(pipe_tag_t);

  // Width of bin * sample_rate before the >> idx_w; never narrower than 64 bits.
  function automatic int freq_prod_w(input int idx_w);
    return (idx_w + 32 > 64) ? idx_w + 32 : 64;
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage pipelined magnitude-squared (re^2 + im^2) of a packed {re, im} sample.
// An opaque tag is delayed alongside the data so callers can attach any sideband.
module fft_mag_sq #(
  parameter  int OUT_W = 22,
  parameter  int TAG_W = 8,
  localparam int MAG_W = 2 * OUT_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               in_valid,
  input  logic [2*OUT_W-1:0] in_result,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [TAG_W-1:0]   out_tag,
  output logic [MAG_W-1:0]   out_mag
);

  logic signed [MAG_W-1:0] re_x;
  logic signed [MAG_W-1:0] im_x;
  logic        [MAG_W-1:0] sq_re;
  logic        [MAG_W-1:0] sq_im;
  logic                    sq_valid;
  logic        [TAG_W-1:0] sq_tag;

  // Sign-extend before squaring so the product is exact; (-2^(W-1))^2 needs 2W-1 bits.
  assign re_x = {{OUT_W{in_result[2*OUT_W-1]}}, in_result[2*OUT_W-1:OUT_W]};
  assign im_x = {{OUT_W{in_result[OUT_W-1]}},   in_result[OUT_W-1:0]};

  // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sq_valid  <= 1'b0;
      sq_tag    <= '0;
      sq_re     <= '0;
      sq_im     <= '0;
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_mag   <= '0;
    end else begin
      sq_valid  <= in_valid;
      sq_tag    <= in_tag;
      sq_re     <= re_x * re_x;
      sq_im     <= im_x * im_x;
      out_valid <= sq_valid;
      out_tag   <= sq_tag;
      out_mag   <= sq_re + sq_im;
    end
  end

endmodule

// File: rtl/fft_peak_tracker.sv
// Per-frame windowed peak search on the fftmain output stream, re-armed every frame.
// Optional neighbour-magnitude outputs for interpolation are enabled by PEAK_INTERP_EN.
module fft_peak_tracker
  import fft_pkg::*;
#(
  parameter  int SAMPLE_RATE = 1000000,
  parameter  int FFT_SIZE    = 2048,
  parameter  int OUT_W       = 22,
  localparam int IDX_W       = $clog2(FFT_SIZE),
  localparam int MAG_W       = 2 * OUT_W
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               in_valid,
  input  logic               in_sync,
  input  logic [2*OUT_W-1:0] in_result,
  input  logic [IDX_W-1:0]   cfg_bin_lo,
  input  logic [IDX_W-1:0]   cfg_bin_hi,
  input  logic [MAG_W-1:0]   cfg_threshold,
  output logic               peak_valid,
  output logic               peak_found,
  output logic [IDX_W-1:0]   peak_bin,
  output logic [MAG_W-1:0]   peak_mag,
  output logic [31:0]        peak_freq,
  output logic               frame_err
`ifdef PEAK_INTERP_EN
  ,
  output logic [MAG_W-1:0]   peak_mag_lo,
  output logic [MAG_W-1:0]   peak_mag_hi
`endif
);

  localparam int PROD_W = freq_prod_w(IDX_W);

  if (FFT_SIZE < 8 || (FFT_SIZE & (FFT_SIZE - 1)) != 0 || IDX_W > MAX_IDX_W) begin : g_bad_size
    $error("fft_peak_tracker: FFT_SIZE must be a power of two, >= 8, within tag width");
  end

  // ---------------------------------------------------------------- input FSM
  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   bin_idx;
  logic [IDX_W-1:0]   bin_idx_nxt;
  logic               err_nxt;
  pipe_tag_t          tag_in;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    bin_idx_nxt = bin_idx;
    err_nxt     = 1'b0;
    tag_in      = '0;
    if (in_valid) begin
      if (in_sync) begin
        err_nxt      = (state == FRAME);
        tag_in.first = 1'b1;
        state_nxt    = FRAME;
        bin_idx_nxt  = IDX_W'(1);
      end else if (state == FRAME) begin
        tag_in.idx  = MAX_IDX_W'(bin_idx);
        tag_in.last = (bin_idx == IDX_W'(FFT_SIZE - 1));
        bin_idx_nxt = bin_idx + 1'b1;
        if (tag_in.last) state_nxt = IDLE;
      end else begin
        tag_in.drop = 1'b1;
      end
    end
  end

  // Window config captured on the sync beat, then delayed to line up with bin 0 at the tracker.
  logic [IDX_W-1:0] cfg1_lo, cfg1_hi, cfg2_lo, cfg2_hi;
  logic [MAG_W-1:0] cfg1_thr, cfg2_thr;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      bin_idx   <= '0;
      frame_err <= 1'b0;
      cfg1_lo   <= '0;
      cfg1_hi   <= '0;
      cfg1_thr  <= '0;
      cfg2_lo   <= '0;
      cfg2_hi   <= '0;
      cfg2_thr  <= '0;
    end else begin
      state     <= state_nxt;
      bin_idx   <= bin_idx_nxt;
      frame_err <= err_nxt;
      if (in_valid && in_sync) begin
        cfg1_lo  <= cfg_bin_lo;
        cfg1_hi  <= cfg_bin_hi;
        cfg1_thr <= cfg_threshold;
      end
      cfg2_lo  <= cfg1_lo;
      cfg2_hi  <= cfg1_hi;
      cfg2_thr <= cfg1_thr;
    end
  end

  // --------------------------------------------------------- magnitude pipe
  logic             m_valid;
  pipe_tag_t        m_tag;
  logic [MAG_W-1:0] m_mag;

  fft_mag_sq #(
    .OUT_W (OUT_W),
    .TAG_W (TAG_W)
  ) u_mag_sq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .in_valid  (in_valid),
    .in_result (in_result),
    .in_tag    (tag_in),
    .out_valid (m_valid),
    .out_tag   (m_tag),
    .out_mag   (m_mag)
  );

  // ----------------------------------------------------------------- tracker
  logic [IDX_W-1:0]     trk_lo, trk_hi;
  logic [MAG_W-1:0]     trk_thr;
  logic                 trk_hit;
  logic [MAG_W-1:0]     trk_max;
  logic [MAX_IDX_W-1:0] trk_bin;

  logic                 beat;
  logic                 publish;
  logic [IDX_W-1:0]     lo_eff, hi_eff;
  logic [MAG_W-1:0]     thr_eff;
  logic                 base_hit;
  logic [MAG_W-1:0]     base_max;
  logic [MAX_IDX_W-1:0] base_bin;
  logic                 in_win;
  logic                 upd;
  logic                 cand_hit;
  logic [MAG_W-1:0]     cand_max;
  logic [MAX_IDX_W-1:0] cand_bin;

  // A first-tagged beat sees a cleared tracker and the config captured with its own sync.
  always_comb begin
    beat     = m_valid && !m_tag.drop;
    publish  = beat && m_tag.last;
    lo_eff   = m_tag.first ? cfg2_lo  : trk_lo;
    hi_eff   = m_tag.first ? cfg2_hi  : trk_hi;
    thr_eff  = m_tag.first ? cfg2_thr : trk_thr;
    base_hit = m_tag.first ? 1'b0     : trk_hit;
    base_max = m_tag.first ? '0       : trk_max;
    base_bin = m_tag.first ? '0       : trk_bin;
    in_win   = (m_tag.idx >= MAX_IDX_W'(lo_eff)) && (m_tag.idx <= MAX_IDX_W'(hi_eff));
    upd      = beat && in_win && (!base_hit || (m_mag > base_max));
    cand_hit = base_hit || upd;
    cand_max = upd ? m_mag     : base_max;
    cand_bin = upd ? m_tag.idx : base_bin;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      trk_lo     <= '0;
      trk_hi     <= '0;
      trk_thr    <= '0;
      trk_hit    <= 1'b0;
      trk_max    <= '0;
      trk_bin    <= '0;
      peak_valid <= 1'b0;
      peak_found <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_freq  <= '0;
    end else begin
      peak_valid <= publish;
      if (beat) begin
        trk_hit <= cand_hit;
        trk_max <= cand_max;
        trk_bin <= cand_bin;
        if (m_tag.first) begin
          trk_lo  <= cfg2_lo;
          trk_hi  <= cfg2_hi;
          trk_thr <= cfg2_thr;
        end
      end
      if (publish) begin
        peak_found <= cand_hit && (cand_max >= thr_eff);
        peak_bin   <= cand_bin[IDX_W-1:0];
        peak_mag   <= cand_max;
        peak_freq  <= 32'((PROD_W'(cand_bin) * PROD_W'(SAMPLE_RATE)) >> IDX_W);
      end
    end
  end

`ifdef PEAK_INTERP_EN
  // ------------------------------------------------- neighbour magnitudes
  logic [MAG_W-1:0] prev_mag;
  logic [MAG_W-1:0] trk_mlo, trk_mhi;
  logic             hi_pend;
  logic [MAG_W-1:0] cand_mlo, cand_mhi;

  // The upper neighbour is still in flight when the max updates; it resolves on the next beat.
  always_comb begin
    cand_mlo = m_tag.first ? '0 : trk_mlo;
    cand_mhi = m_tag.first ? '0 : trk_mhi;
    if (upd) begin
      cand_mlo = m_tag.first ? '0 : prev_mag;
      cand_mhi = '0;
    end else if (hi_pend && !m_tag.first) begin
      cand_mhi = m_mag;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prev_mag    <= '0;
      trk_mlo     <= '0;
      trk_mhi     <= '0;
      hi_pend     <= 1'b0;
      peak_mag_lo <= '0;
      peak_mag_hi <= '0;
    end else begin
      if (beat) begin
        prev_mag <= m_mag;
        trk_mlo  <= cand_mlo;
        trk_mhi  <= cand_mhi;
        hi_pend  <= upd;
      end
      if (publish) begin
        peak_mag_lo <= cand_mlo;
        peak_mag_hi <= cand_mhi;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fft_peak_tracker.sv
// Randomized self-checking bench for fft_peak_tracker: a per-frame reference search over
// the generated bin magnitudes feeds a scoreboard checked on every peak_valid pulse.
module tb_fft_peak_tracker;

  localparam int SAMPLE_RATE = 1000000;
  localparam int FFT_SIZE    = 2048;
  localparam int OUT_W       = 22;
  localparam int IDX_W       = $clog2(FFT_SIZE);
  localparam int MAG_W       = 2 * OUT_W;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               in_valid;
  logic               in_sync;
  logic [2*OUT_W-1:0] in_result;
  logic [IDX_W-1:0]   cfg_bin_lo;
  logic [IDX_W-1:0]   cfg_bin_hi;
  logic [MAG_W-1:0]   cfg_threshold;
  logic               peak_valid;
  logic               peak_found;
  logic [IDX_W-1:0]   peak_bin;
  logic [MAG_W-1:0]   peak_mag;
  logic [31:0]        peak_freq;
  logic               frame_err;
`ifdef PEAK_INTERP_EN
  logic [MAG_W-1:0]   peak_mag_lo;
  logic [MAG_W-1:0]   peak_mag_hi;
`endif

  fft_peak_tracker #(
    .SAMPLE_RATE (SAMPLE_RATE),
    .FFT_SIZE    (FFT_SIZE),
    .OUT_W       (OUT_W)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid      (in_valid),
    .in_sync       (in_sync),
    .in_result     (in_result),
    .cfg_bin_lo    (cfg_bin_lo),
    .cfg_bin_hi    (cfg_bin_hi),
    .cfg_threshold (cfg_threshold),
    .peak_valid    (peak_valid),
    .peak_found    (peak_found),
    .peak_bin      (peak_bin),
    .peak_mag      (peak_mag),
    .peak_freq     (peak_freq),
    .frame_err     (frame_err)
`ifdef PEAK_INTERP_EN
    ,
    .peak_mag_lo   (peak_mag_lo),
    .peak_mag_hi   (peak_mag_hi)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int     bin;
    longint mag;
    bit     found;
    longint freq;
    longint mlo;
    longint mhi;
    int     drive_cyc;
  } exp_t;

  exp_t   exp_q[$];
  int     cyc      = 0;
  int     err_seen = 0;
  int     err_exp  = 0;
  int     pulses   = 0;
  int     re_a[FFT_SIZE];
  int     im_a[FFT_SIZE];

  always @(posedge clk_in) cyc++;

  // Scoreboard: each peak_valid pulse must match the oldest outstanding frame.
  always @(negedge clk_in) begin
    exp_t e;
    if (frame_err) err_seen++;
    if (peak_valid) begin
      pulses++;
      check("pulse_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("latency",    64'(cyc - e.drive_cyc), 64'd3);
        check("peak_bin",   64'(peak_bin),   64'(e.bin));
        check("peak_mag",   64'(peak_mag),   64'(e.mag));
        check("peak_found", 64'(peak_found), 64'(e.found));
        check("peak_freq",  64'(peak_freq),  64'(e.freq));
`ifdef PEAK_INTERP_EN
        check("peak_mag_lo", 64'(peak_mag_lo), 64'(e.mlo));
        check("peak_mag_hi", 64'(peak_mag_hi), 64'(e.mhi));
`endif
      end
    end
  end

  function automatic longint mag_of(input int b);
    return longint'(re_a[b]) * re_a[b] + longint'(im_a[b]) * im_a[b];
  endfunction

  // Reference: scan the window in bin order, keep the first strictly-largest magnitude.
  function automatic exp_t model(input int lo, input int hi, input longint thr);
    exp_t   e;
    int     best = -1;
    longint bm   = 0;
    for (int b = lo; b <= hi; b++)
      if (best < 0 || mag_of(b) > bm) begin
        best = b;
        bm   = mag_of(b);
      end
    e.bin       = (best < 0) ? 0 : best;
    e.mag       = bm;
    e.found     = (best >= 0) && (bm >= thr);
    e.freq      = ((longint'(e.bin) * SAMPLE_RATE) >> IDX_W) & 64'hFFFF_FFFF;
    e.mlo       = (best > 0) ? mag_of(best - 1) : 0;
    e.mhi       = (best >= 0 && best < FFT_SIZE - 1) ? mag_of(best + 1) : 0;
    e.drive_cyc = 0;
    return e;
  endfunction

  task automatic fill(input int amp);
    for (int b = 0; b < FFT_SIZE; b++) begin
      re_a[b] = int'($urandom_range(2 * amp)) - amp;
      im_a[b] = int'($urandom_range(2 * amp)) - amp;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  // Valid non-sync beats while the tracker waits for a frame; they must be ignored.
  task automatic junk(input int n);
    repeat (n) begin
      in_valid      = 1'b1;
      in_sync       = 1'b0;
      in_result     = {$urandom, $urandom};
      cfg_bin_lo    = IDX_W'($urandom);
      cfg_bin_hi    = IDX_W'($urandom);
      @(negedge clk_in);
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_frame(input int n_beats, input int gap_pct, input int lo, input int hi,
                             input longint thr, input bit push);
    exp_t e;
    for (int b = 0; b < n_beats; b++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        in_valid  = 1'b0;
        in_sync   = 1'($urandom);
        in_result = {$urandom, $urandom};
        @(negedge clk_in);
      end
      in_valid  = 1'b1;
      in_sync   = (b == 0);
      in_result = {OUT_W'(re_a[b]), OUT_W'(im_a[b])};
      if (b == 0) begin
        cfg_bin_lo    = IDX_W'(lo);
        cfg_bin_hi    = IDX_W'(hi);
        cfg_threshold = MAG_W'(thr);
      end else begin
        cfg_bin_lo    = IDX_W'($urandom);
        cfg_bin_hi    = IDX_W'($urandom);
        cfg_threshold = MAG_W'({$urandom, $urandom});
      end
      if (b == FFT_SIZE - 1 && push) begin
        e           = model(lo, hi, thr);
        e.drive_cyc = cyc;
        exp_q.push_back(e);
      end
      @(negedge clk_in);
    end
  endtask

  task automatic wait_drain(input string tag);
    idle(1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk_in);
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pk[3];
    int p0;
    int lo;
    int hi;

    pk            = '{45, 70, 110};
    rst_in        = 1'b1;
    in_valid      = 1'b0;
    in_sync       = 1'b0;
    in_result     = '0;
    cfg_bin_lo    = '0;
    cfg_bin_hi    = '0;
    cfg_threshold = '0;
    repeat (3) @(negedge clk_in);
    check("rst_peak_valid", 64'(peak_valid), 64'd0);
    check("rst_peak_found", 64'(peak_found), 64'd0);
    check("rst_peak_bin",   64'(peak_bin),   64'd0);
    check("rst_peak_mag",   64'(peak_mag),   64'd0);
    check("rst_peak_freq",  64'(peak_freq),  64'd0);
    check("rst_frame_err",  64'(frame_err),  64'd0);
    rst_in = 1'b0;
    idle(2);
    junk(6);

    // Tone at bin 80 over low noise.
    fill(7);
    re_a[80] = 1000;
    im_a[80] = 0;
    drive_frame(FFT_SIZE, 0, 41, 119, 1000, 1);
    wait_drain("tone");
    idle(5);
    check("tone_hold_bin",   64'(peak_bin),   64'd80);
    check("tone_hold_mag",   64'(peak_mag),   64'd1000000);
    check("tone_hold_freq",  64'(peak_freq),  64'd39062);
    check("tone_hold_found", 64'(peak_found), 64'd1);

    // Equal peaks at 50 and 90, larger one outside the window.
    fill(7);
    re_a[50]  = 200;  im_a[50]  = 0;
    re_a[90]  = 0;    im_a[90]  = 200;
    re_a[200] = 3000; im_a[200] = 0;
    drive_frame(FFT_SIZE, 0, 41, 119, 1000, 1);
    wait_drain("tie");
    check("tie_bin", 64'(peak_bin), 64'd50);

    // Peak below threshold still reports its bin.
    fill(5);
    re_a[60] = 20;
    im_a[60] = 10;
    drive_frame(FFT_SIZE, 0, 41, 119, 1000, 1);
    wait_drain("below_thr");
    check("below_thr_found", 64'(peak_found), 64'd0);
    check("below_thr_mag",   64'(peak_mag),   64'd500);

    // Inverted window publishes an empty result.
    fill(100);
    drive_frame(FFT_SIZE, 0, 100, 60, 0, 1);
    wait_drain("empty");
    check("empty_mag", 64'(peak_mag), 64'd0);

    // Sync re-asserted at bin 1000: partial frame dropped, next frame reported.
    fill(50);
    drive_frame(1000, 0, 0, FFT_SIZE - 1, 0, 0);
    err_exp++;
    fill(50);
    re_a[300] = 5000;
    drive_frame(FFT_SIZE, 0, 0, FFT_SIZE - 1, 0, 1);
    wait_drain("resync");
    check("resync_frame_err", 64'(err_seen), 64'(err_exp));

    // Three back-to-back frames with random input gaps.
    p0 = pulses;
    for (int k = 0; k < 3; k++) begin
      fill(30);
      re_a[pk[k]] = 2000;
      drive_frame(FFT_SIZE, 20, 41, 119, 1000, 1);
    end
    wait_drain("b2b_gaps");
    check("b2b_gaps_pulses", 64'(pulses - p0), 64'd3);

    // Two frames with zero idle beats between them.
    for (int k = 0; k < 2; k++) begin
      fill(30);
      re_a[pk[k + 1]] = 1500;
      drive_frame(FFT_SIZE, 0, 41, 119, 1000, 1);
    end
    wait_drain("b2b_tight");

    // Reset in the middle of the second frame.
    fill(30);
    re_a[45] = 2000;
    drive_frame(FFT_SIZE, 10, 41, 119, 1000, 1);
    p0 = pulses;
    fill(30);
    drive_frame(1200, 10, 41, 119, 1000, 0);
    check("pre_rst_pulse", 64'(pulses - p0), 64'd1);
    rst_in = 1'b1;
    #1;
    check("mid_rst_bin",   64'(peak_bin),   64'd0);
    check("mid_rst_mag",   64'(peak_mag),   64'd0);
    check("mid_rst_freq",  64'(peak_freq),  64'd0);
    check("mid_rst_found", 64'(peak_found), 64'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    idle(10);
    check("post_rst_no_pulse", 64'(pulses - p0), 64'd1);
    fill(30);
    re_a[110] = 2500;
    drive_frame(FFT_SIZE, 10, 41, 119, 1000, 1);
    wait_drain("post_rst");

    // Full-scale negative input on the last bin, threshold equal to the peak.
    fill(1000);
    re_a[FFT_SIZE - 1] = -(1 << (OUT_W - 1));
    im_a[FFT_SIZE - 1] = -(1 << (OUT_W - 1));
    drive_frame(FFT_SIZE, 0, 0, FFT_SIZE - 1, longint'(1) << (2 * OUT_W - 1), 1);
    wait_drain("full_scale");
    check("full_scale_mag", 64'(peak_mag), 64'(longint'(1) << (2 * OUT_W - 1)));

    // Random frames: random window (possibly inverted), threshold taken from a random bin.
    for (int k = 0; k < 4; k++) begin
      fill(1 << 20);
      lo = int'($urandom_range(FFT_SIZE - 1));
      hi = int'($urandom_range(FFT_SIZE - 1));
      drive_frame(FFT_SIZE, 5, lo, hi, mag_of(int'($urandom_range(FFT_SIZE - 1))), 1);
    end
    wait_drain("random");

`ifdef PEAK_INTERP_EN
    fill(5);
    re_a[79] = 60;   im_a[79] = 20;
    re_a[80] = 1000; im_a[80] = 0;
    re_a[81] = 60;   im_a[81] = 50;
    drive_frame(FFT_SIZE, 0, 41, 119, 1000, 1);
    wait_drain("interp");
    check("interp_lo", 64'(peak_mag_lo), 64'd4000);
    check("interp_hi", 64'(peak_mag_hi), 64'd6100);

    fill(5);
    re_a[0] = 500;
    drive_frame(FFT_SIZE, 0, 0, 10, 1000, 1);
    wait_drain("interp_bin0");
    check("interp_bin0_lo", 64'(peak_mag_lo), 64'd0);
`endif

    idle(5);
    check("frame_err_total", 64'(err_seen), 64'(err_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
